// File: rtl/sd_pkg.sv
// sd_pkg: shared types and helpers for the sigma-delta frame sequencer.
//   - sd_state_e   : sequencer states (IDLE, ACC)
//   - SD_POS_BIT / SD_NEG_BIT : bitstream encoding (0 = +1, 1 = -1)
//   - sd_bit_val() : map a stream bit to signed +/-1
//   - sd_sat()     : clip a signed value to a w-bit two's complement range
package sd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } sd_state_e;

    localparam logic SD_POS_BIT = 1'b0;
    localparam logic SD_NEG_BIT = 1'b1;

    function automatic logic signed [1:0] sd_bit_val(input logic b);
        return (b == SD_NEG_BIT) ? -2'sd1 : 2'sd1;
    endfunction

    function automatic logic signed [31:0] sd_sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/sd_window_accum.sv
// sd_window_accum: per-window sample counter and the two signed accumulators.
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : hold count/acc/eacc at zero (sequencer not running)
//   take_i        : a sample is accepted this cycle
//   x_bit_i       : input stream bit
//   y_bit_i       : feedback stream bit
//   osr_q_i       : latched window length (already forced >= 1)
//   last_o        : the next accepted sample closes the window
//   acc_sum_o     : acc + x for the sample currently presented
//   eacc_sum_o    : eacc + e for the sample currently presented
module sd_window_accum
    import sd_pkg::*;
#(
    parameter int OSR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    take_i,
    input  logic                    x_bit_i,
    input  logic                    y_bit_i,
    input  logic [OSR_W-1:0]        osr_q_i,
    output logic                    last_o,
    output logic signed [OSR_W:0]   acc_sum_o,
    output logic signed [OSR_W:0]   eacc_sum_o
);

    logic [OSR_W-1:0]      count_q, count_d;
    logic signed [OSR_W:0] acc_q, acc_d;
    logic signed [OSR_W:0] eacc_q, eacc_d;
    logic signed [1:0]     x_val, y_val, e_val;
    logic signed [2:0]     diff;

    assign x_val = sd_bit_val(x_bit_i);
    assign y_val = sd_bit_val(y_bit_i);
    // (x - y) is -2, 0 or +2; dropping the LSB is an exact divide by two.
    assign diff  = {x_val[1], x_val} - {y_val[1], y_val};
    assign e_val = diff[2:1];

    assign last_o     = (count_q == osr_q_i - OSR_W'(1));
    assign acc_sum_o  = acc_q  + {{(OSR_W-1){x_val[1]}}, x_val};
    assign eacc_sum_o = eacc_q + {{(OSR_W-1){e_val[1]}}, e_val};

    always_comb begin
        count_d = count_q;
        acc_d   = acc_q;
        eacc_d  = eacc_q;
        if (clear_i) begin
            count_d = '0;
            acc_d   = '0;
            eacc_d  = '0;
        end else if (take_i) begin
            if (last_o) begin
                // Window closes; the next one starts on the following sample.
                count_d = '0;
                acc_d   = '0;
                eacc_d  = '0;
            end else begin
                count_d = count_q + OSR_W'(1);
                acc_d   = acc_sum_o;
                eacc_d  = eacc_sum_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            acc_q   <= '0;
            eacc_q  <= '0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            eacc_q  <= eacc_d;
        end
    end

endmodule

// File: rtl/sd_frame_sequencer.sv
// sd_frame_sequencer: frames the 1-bit input and feedback streams into
// osr-sample windows and emits one word per window through a one-entry
// valid/ready output register.
//   clk, rst            : clock, synchronous active-high reset
//   en                  : run enable; dropping it in ACC aborts the window
//   osr                 : window length, latched on IDLE->ACC (0 acts as 1)
//   in, fbin, in_valid  : sample pair and its valid
//   in_ready            : sample accepted when in_valid & in_ready
//   out                 : sign-extended window sum of in
//   err                 : saturated window sum of (x-y)/2
//   mismatch            : |err| > MISMATCH_TH (meaningful while out_valid)
//   out_valid/out_ready : output handshake
//   busy                : sequencer is in ACC
module sd_frame_sequencer
    import sd_pkg::*;
#(
    parameter int OUT_W       = 24,
    parameter int OSR_W       = 16,
    parameter int ERR_W       = 12,
    parameter int MISMATCH_TH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [OSR_W-1:0] osr,
    input  logic             in,
    input  logic             fbin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out,
    output logic [ERR_W-1:0] err,
    output logic             mismatch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    generate
        if (OUT_W < OSR_W + 2) begin : g_bad_out_w
            $error("sd_frame_sequencer: OUT_W must be at least OSR_W+2");
        end
    endgenerate

    sd_state_e             state_q;
    logic [OSR_W-1:0]      osr_q;
    logic [OUT_W-1:0]      out_q, out_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic                  mismatch_q, mismatch_d;
    logic                  out_valid_q;

    logic                  run;
    logic                  last;
    logic                  accept;
    logic                  close;
    logic signed [OSR_W:0] acc_sum;
    logic signed [OSR_W:0] eacc_sum;
    logic signed [31:0]    eacc_wide;

    // Accumulation only proceeds while enabled in ACC; en=0 both blocks the
    // sample this cycle and wipes the partial window.
    assign run      = (state_q == ACC) && en;
    // Stall only when the closing sample would land on a full output register.
    assign in_ready = run && !(last && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign close    = accept && last;
    assign busy     = (state_q == ACC);

    sd_window_accum #(
        .OSR_W(OSR_W)
    ) u_accum (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!run),
        .take_i    (accept),
        .x_bit_i   (in),
        .y_bit_i   (fbin),
        .osr_q_i   (osr_q),
        .last_o    (last),
        .acc_sum_o (acc_sum),
        .eacc_sum_o(eacc_sum)
    );

    assign eacc_wide  = 32'(eacc_sum);
    assign out_d      = {{(OUT_W-OSR_W-1){acc_sum[OSR_W]}}, acc_sum};
    assign err_d      = ERR_W'(sd_sat(eacc_wide, ERR_W));
    assign mismatch_d = (eacc_wide > MISMATCH_TH) || (eacc_wide < -MISMATCH_TH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            osr_q       <= OSR_W'(1);
            out_q       <= '0;
            err_q       <= '0;
            mismatch_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        osr_q   <= (osr == '0) ? OSR_W'(1) : osr;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    if (!en) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // A close is only possible when the register is empty or being
            // drained this cycle, so loading here never drops a word.
            if (close) begin
                out_q       <= out_d;
                err_q       <= err_d;
                mismatch_q  <= mismatch_d;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out       = out_q;
    assign err       = err_q;
    assign mismatch  = mismatch_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/sd_frame_sequencer.md
Name: sd_frame_sequencer

Overview:
Frames the 1-bit sigma-delta input stream (in) and its loop feedback stream (fbin) into OSR-sample decimation windows.
- Per window it accumulates a signed sum of the input and a signed loop-error sum, then emits a 24-bit word through a one-entry valid/ready output register.
- It sits between the bitstream source and the word consumer (results logger / downstream filter).
- It sequences start, abort and backpressure for the shared accumulator datapath.

Parameters:
OUT_W, 24, output word width; elaboration error if OUT_W < OSR_W+2
OSR_W, 16, width of osr / sample counter
ERR_W, 12, width of err output (saturating)
MISMATCH_TH, 3, |err| strictly above this sets mismatch

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
en  in  1  run enable
osr  in  OSR_W  window length; latched on IDLE->ACC; 0 treated as 1
in  in  1  input bit; 1 = -1, 0 = +1
fbin  in  1  feedback bit; same encoding
in_valid  in  1  in/fbin valid
in_ready  out  1  sample accepted when in_valid & in_ready
out  out  OUT_W  sign-extended window sum of in
err  out  ERR_W  signed window sum of (x-y)/2, saturated to ERR_W
mismatch  out  1  |err| > MISMATCH_TH, qualified by out_valid
out_valid  out  1  out/err/mismatch valid
out_ready  in  1  consumer accepts
busy  out  1  state == ACC

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; count, acc and eacc = 0; out=0, err=0, mismatch=0, out_valid=0, in_ready=0, busy=0. Overrides everything, including mid-frame and a pending out_valid.
- Sample mapping: x = in ? -1 : +1; y = fbin ? -1 : +1; e = (x-y)/2, giving -1, 0 or +1.
- acc is OSR_W+1 bits signed and cannot overflow. eacc is OSR_W+1 bits, saturated to ERR_W only at output.
- FSM states: IDLE, ACC.
- IDLE:
  - in_ready=0.
  - en=1 -> latch osr_q = max(osr,1); clear count/acc/eacc; go to ACC next cycle.
- ACC, ready rule:
  - last = (count == osr_q-1).
  - in_ready = !(last & out_valid & !out_ready).
  - Effect: stall only when the closing sample would find the output register full.
- ACC, each accepted sample with last=0: acc+=x, eacc+=e, count+=1.
- ACC, accepted sample with last=1 (frame close):
  - Next edge: out <= sext(acc+x); err <= sat(eacc+e); mismatch <= |eacc+e| > MISMATCH_TH; out_valid <= 1.
  - count/acc/eacc <= 0.
  - The next window starts immediately with no gap cycle.
- Latency: out_valid rises the cycle after the closing sample's accepting edge.
- Output register:
  - out_valid & out_ready with no frame close that cycle -> out_valid <= 0; out/err/mismatch hold their values.
  - Simultaneous accept and frame close -> out_valid stays 1 with the new data.
  - out, err and mismatch never change while out_valid & !out_ready.
- en=0 in ACC (abort):
  - Partial window is discarded; state -> IDLE next cycle; in_ready=0 from that cycle.
  - A sample presented in the abort cycle is not accepted (in_ready is forced 0 when en=0).
  - A pending output word stays valid until accepted.
- osr changes while in ACC are ignored until the next IDLE->ACC.
- in_valid=0 cycles: no state change; count holds (no timeout).

Decomposition:
- Package sd_pkg holds:
  - state enum (IDLE, ACC)
  - bit encoding constants (SD_POS_BIT=0, SD_NEG_BIT=1)
  - function mapping a bit to signed ±1
  - saturate function
- One sub-module: sd_window_accum (count, acc, eacc, clear, last flag).
- sd_frame_sequencer keeps the FSM, the ready logic and the output register.

Test Plan:
1. osr=4, en=1, in=0 and fbin=0 x4, in_valid=1, out_ready=1 -> out=0x000004, err=0, mismatch=0; out_valid one cycle after the 4th accept, for 1 cycle.
2. osr=4, in=1 and fbin=1 x4 -> out=0xFFFFFC (-4), err=0.
3. osr=8, in alternating 0,1,..., fbin=1 constant -> out=0, err=+4, mismatch=1 (TH=3). Continuous windows with no gap cycle.
4. osr=2, out_ready=0:
   - Frame 1 completes, out_valid=1.
   - Next sample accepted; in_ready=0 while the following sample would close a frame.
   - Raise out_ready for 1 cycle -> frame 2 closes on that cycle, out_valid stays 1, out updates.
5. osr=8, drop en after 3 accepts -> no out_valid, in_ready=0 next cycle, busy=0. Re-enable with osr=0 -> every accepted sample emits a word (±1).
6. rst=1 mid-frame with out_valid=1 -> next edge: all outputs 0, IDLE. Restart gives a correct first window (acc not carried over).
